// File: rtl/sample_decim_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_decim_ctrl_if : control, sample and result signals of the decimator
// Rev 1.0
// ---------------------------------------------------------------------------
interface sample_decim_ctrl_if #(
  parameter int DATA_SIZE = 24
);
  logic                 enable;
  logic [2:0]           log2_factor;
  logic                 ready_i2s;
  logic [DATA_SIZE-1:0] audio_data_in;
  logic                 clear_status;
  logic                 out_ready;
  logic                 out_valid;
  logic [DATA_SIZE-1:0] audio_data_out;
  logic                 busy;
  logic                 overrun;
  logic [15:0]          overrun_count;

  modport master (
    output enable, log2_factor, ready_i2s, audio_data_in, clear_status, out_ready,
    input  out_valid, audio_data_out, busy, overrun, overrun_count
  );

  modport slave (
    input  enable, log2_factor, ready_i2s, audio_data_in, clear_status, out_ready,
    output out_valid, audio_data_out, busy, overrun, overrun_count
  );
endinterface
`default_nettype wire

// File: rtl/sample_decim_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_decim_ctrl : block-average decimator (2^cfg samples -> 1) with
//                     valid/ready output and sticky overrun reporting
// Rev 1.0
// ---------------------------------------------------------------------------
module sample_decim_ctrl #(
  parameter int DATA_SIZE = 24,
  parameter int MAX_LOG2  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sample_decim_ctrl_if.slave bus
);
  localparam int ACC_W = DATA_SIZE + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2;
  localparam logic [2:0] c_max_cfg = 3'(MAX_LOG2);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 r_state;
  logic [2:0]             r_cfg;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out_valid;
  logic [DATA_SIZE-1:0]   r_out_data;
  logic                   r_busy;
  logic                   r_overrun;
  logic [15:0]            r_ovr_cnt;

  logic [CNT_W-1:0]        w_cnt_max;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shift;
  logic                    w_strobe;
  logic                    w_load;
  logic                    w_xfer;
  logic                    w_ovr;

  always_comb begin
    w_cnt_max = ~({CNT_W{1'b1}} << r_cfg);
    w_sum     = r_acc + {{MAX_LOG2{bus.audio_data_in[DATA_SIZE-1]}}, bus.audio_data_in};
    w_shift   = w_sum >>> r_cfg;
    w_strobe  = (r_state == S_RUN) && bus.enable && bus.ready_i2s;
    w_load    = w_strobe && (r_cnt == w_cnt_max);
    w_xfer    = r_out_valid && bus.out_ready;
    // A load racing a transfer replaces an accepted result, so it is not an overrun.
    w_ovr     = w_load && r_out_valid && !bus.out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cfg       <= 3'd0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_ovr_cnt   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cfg   <= (bus.log2_factor > c_max_cfg) ? c_max_cfg : bus.log2_factor;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (!bus.enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else if (bus.ready_i2s) begin
            if (w_load) begin
              r_acc <= '0;
              r_cnt <= '0;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_shift[DATA_SIZE-1:0];
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end

      if (bus.clear_status) begin
        r_overrun <= w_ovr;
        r_ovr_cnt <= w_ovr ? 16'd1 : 16'd0;
      end else if (w_ovr) begin
        r_overrun <= 1'b1;
        if (r_ovr_cnt != 16'hFFFF) r_ovr_cnt <= r_ovr_cnt + 16'd1;
      end
    end
  end

  assign bus.out_valid      = r_out_valid;
  assign bus.audio_data_out = r_out_data;
  assign bus.busy           = r_busy;
  assign bus.overrun        = r_overrun;
  assign bus.overrun_count  = r_ovr_cnt;
endmodule
`default_nettype wire
